// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / writeback stage in front of the 32-bit ALU.
// Holds a small register file and runs one command at a time: IDLE -> EXEC -> RESP.
module alu_issue_stage #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic              cmd_imm_en,
  input  logic [31:0]       cmd_imm,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_f,
  input  logic [31:0]       alu_y,
  input  logic              alu_zero,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              res_zero,
  output logic [ADDR_W-1:0] res_rd,
  output logic              res_err,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state;
  logic [31:0]         rf [DEPTH];
  logic [31:0]         op_a;
  logic [31:0]         op_b;
  logic [2:0]          op_f;
  logic [ADDR_W-1:0]   op_rd;
  logic                accept;
  logic                op_legal;
  logic                wb_en;

  // Both handshakes: a transfer happens at a rising edge where valid and ready
  // are both high; a producer holds valid and its payload until that edge.
  assign cmd_ready = rst_n && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign op_legal  = !(op_f inside {3'd3, 3'd4, 3'd5});
  assign wb_en     = (state == S_EXEC) && op_legal && (op_rd != '0);

  assign alu_a     = (state == S_EXEC) ? op_a : '0;
  assign alu_b     = (state == S_EXEC) ? op_b : '0;
  assign alu_f     = (state == S_EXEC) ? op_f : '0;
  assign dbg_state = state;

  // Entry 0 is never written, so it reads as zero without a read-side mux.
  // The writeback assignment comes last so it wins a same-edge collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) rf[wr_addr] <= wr_data;
      if (wb_en) rf[op_rd] <= alu_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_f      <= '0;
      op_rd     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_rd    <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a  <= rf[cmd_rs1];
            op_b  <= cmd_imm_en ? cmd_imm : rf[cmd_rs2];
            op_f  <= cmd_op;
            op_rd <= cmd_rd;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_data  <= alu_y;
          res_zero  <= alu_zero;
          res_err   <= !op_legal;
          res_rd    <= op_rd;
          res_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
